// File: rtl/ssd_scanner_if.sv
// rtl/ssd_scanner_if.sv - value load handshake between a probe core and the scanner
interface ssd_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic                    val_valid_in;
    logic                    val_ready_out;
    logic                    mode_in;
    logic                    blank_zeros_in;

    modport master (
        output val_in,
        output val_valid_in,
        output mode_in,
        output blank_zeros_in,
        input  val_ready_out
    );

    modport slave (
        input  val_in,
        input  val_valid_in,
        input  mode_in,
        input  blank_zeros_in,
        output val_ready_out
    );
endinterface

// File: rtl/ssd_scanner.sv
// rtl/ssd_scanner.sv - multiplexed seven-segment scanner with hex/decimal rendering
module ssd_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_PERIOD = 100000,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    ssd_scanner_if.slave            load_if,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [BRIGHT_WIDTH-1:0] brightness_in,
    output logic                    overflow_out,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);
    localparam int W     = 4 * NUM_DIGITS;
    localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BIT_W = $clog2(W + 1);
    localparam int PW    = CNT_W + BRIGHT_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_ready;
    logic                    w_hs;

    logic [W-1:0]            r_shift;
    logic [W-1:0]            r_bcd;
    logic [W-1:0]            w_bcd_adj;
    logic                    r_ovf_sticky;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic                    r_blank_pend;

    logic [W-1:0]            r_disp;
    logic                    r_dash;
    logic                    r_blank;
    logic                    r_ovf_out;

    logic [CNT_W-1:0]        r_scan_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_upper_zero;
    logic                    w_blanked;
    logic [PW-1:0]           w_on_cycles;
    logic                    w_on;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_cat;
    logic                    r_dp;

    function automatic logic [6:0] f_font(input logic [3:0] n);
        case (n)
            4'h0:    f_font = 7'b1000000;
            4'h1:    f_font = 7'b1111001;
            4'h2:    f_font = 7'b0100100;
            4'h3:    f_font = 7'b0110000;
            4'h4:    f_font = 7'b0011001;
            4'h5:    f_font = 7'b0010010;
            4'h6:    f_font = 7'b0000010;
            4'h7:    f_font = 7'b1111000;
            4'h8:    f_font = 7'b0000000;
            4'h9:    f_font = 7'b0010000;
            4'hA:    f_font = 7'b0001000;
            4'hB:    f_font = 7'b0000011;
            4'hC:    f_font = 7'b1000110;
            4'hD:    f_font = 7'b0100001;
            4'hE:    f_font = 7'b0000110;
            default: f_font = 7'b0001110;
        endcase
    endfunction

    assign w_ready               = (r_state == S_IDLE);
    assign w_hs                  = w_ready && load_if.val_valid_in;
    assign load_if.val_ready_out = w_ready;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_hs && load_if.mode_in) w_next_state = S_SHIFT;
            S_SHIFT:  if (r_bit_cnt == BIT_W'(W - 1)) w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Double-dabble correction applied before each shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shift      <= '0;
            r_bcd        <= '0;
            r_ovf_sticky <= 1'b0;
            r_bit_cnt    <= '0;
            r_blank_pend <= 1'b0;
            r_disp       <= '0;
            r_dash       <= 1'b0;
            r_blank      <= 1'b0;
            r_ovf_out    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs && !load_if.mode_in) begin
                        r_disp    <= load_if.val_in;
                        r_dash    <= 1'b0;
                        r_blank   <= load_if.blank_zeros_in;
                        r_ovf_out <= 1'b0;
                    end else if (w_hs) begin
                        r_shift      <= load_if.val_in;
                        r_bcd        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_bit_cnt    <= '0;
                        r_blank_pend <= load_if.blank_zeros_in;
                    end
                end
                S_SHIFT: begin
                    r_bcd     <= {w_bcd_adj[W-2:0], r_shift[W-1]};
                    r_shift   <= {r_shift[W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    if (w_bcd_adj[W-1]) r_ovf_sticky <= 1'b1;
                end
                S_COMMIT: begin
                    r_disp    <= r_bcd;
                    r_dash    <= r_ovf_sticky;
                    r_blank   <= r_blank_pend;
                    r_ovf_out <= r_ovf_sticky;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == CNT_W'(DIGIT_PERIOD - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        w_nib        = 4'h0;
        w_dp_sel     = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nib    = r_disp[i*4 +: 4];
                w_dp_sel = dp_in[i];
            end
            if ((IDX_W'(i) >= r_digit_idx) && (r_disp[i*4 +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_blanked   = r_blank && !r_dash && (r_digit_idx != '0) && w_upper_zero;
    assign w_on_cycles = ((PW'(brightness_in) + PW'(1)) * PW'(DIGIT_PERIOD)) >> BRIGHT_WIDTH;
    assign w_on        = (PW'(r_scan_cnt) < w_on_cycles) && !w_blanked;
    assign w_seg       = r_dash ? 7'b0111111 : f_font(w_nib);

    always_comb begin
        w_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_on && (r_digit_idx == IDX_W'(i))) w_an[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_an  <= '1;
            r_cat <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_cat <= w_on ? w_seg : 7'h7F;
            r_dp  <= w_on ? ~w_dp_sel : 1'b1;
        end
    end

    assign an_out       = r_an;
    assign cat_out      = r_cat;
    assign dp_out       = r_dp;
    assign overflow_out = r_ovf_out;
endmodule

// File: doc/ssd_scanner.md
# ssd_scanner

Parametrised seven-segment scanner for the Nexys A7 debug examples, replacing the fixed 8-digit hex-only `ssd` driver. It drives any number of multiplexed digits from a packed value and can render that value as hex or as decimal. Decimal rendering uses a sequential double-dabble converter with overflow indication. It also adds leading-zero blanking, per-digit decimal points, PWM brightness and a valid/ready load handshake, so probe cores can push values without tearing the display.

## Interface
- NUM_DIGITS, 8: number of multiplexed digits; value width is W = 4*NUM_DIGITS.
- DIGIT_PERIOD, 100000: clock cycles each digit is selected; must be ≥ 2^BRIGHT_WIDTH.
- BRIGHT_WIDTH, 4: width of the brightness control.

- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- val_in  input  W  value to display; digit 0 is the rightmost digit (LSBs).
- val_valid_in  input  1  val_in, mode_in and blank_zeros_in are valid.
- val_ready_out  output  1  scanner can accept a value.
- mode_in  input  1  0 = hex, 1 = unsigned decimal; sampled at the handshake.
- blank_zeros_in  input  1  suppress leading zeros; sampled at the handshake.
- dp_in  input  NUM_DIGITS  decimal point per digit; used live, not latched.
- brightness_in  input  BRIGHT_WIDTH  0 = dimmest, all-ones = full on; used live.
- overflow_out  output  1  last committed decimal value was ≥ 10^NUM_DIGITS.
- cat_out  output  7  {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal-point cathode, active-low.
- an_out  output  NUM_DIGITS  digit anodes, active-low; at most one low at a time.

## Operation
- **Load FSM:** three states, IDLE, SHIFT and COMMIT. val_ready_out = (state == IDLE). A handshake occurs when valid and ready are both high on the same edge.
  - Hex mode: at the handshake, val_in is written straight into the display register. overflow_out is cleared. The FSM stays in IDLE.
  - Decimal mode: at the handshake, val_in is latched into a shift register, the BCD register (NUM_DIGITS BCD digits) is cleared, and the sticky overflow flag is cleared. The FSM moves to SHIFT.
- **SHIFT (exactly W cycles):**
  - Each cycle, every BCD digit ≥ 5 first has 3 added.
  - Then {bcd, shift} is shifted left by 1.
  - Any 1 shifted out of the top BCD digit sets the sticky overflow flag.
  - After the W-th shift, the FSM moves to COMMIT.
- **COMMIT (1 cycle):** the display register receives the BCD result, or all-dash digits if overflow is set. overflow_out is updated. The FSM returns to IDLE.
- **Blanking:** the blank flag is latched with each value. When set, every digit above the most significant non-zero digit is blanked (all segments off). Digit 0 is never blanked. Digits are not blanked during overflow display.
- **dp:** dp_out = ~dp_in[current digit] whenever that digit's anode is on, regardless of blanking.
- **Font:** standard hex font, for example 0=1000000, 1=1111001, 4=0011001, B=0000011, E=0000110, F=0001110. Dash = 0111111.
- **Scan:**
  - scan_cnt counts 0..DIGIT_PERIOD-1.
  - At wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
  - The anode is on while scan_cnt < on_cycles, where on_cycles = ((brightness_in+1)*DIGIT_PERIOD) >> BRIGHT_WIDTH.
  - At full brightness the anode is on for the whole slot.
- **Input rules:**
  - val_valid_in is ignored while ready is low.
  - A mode_in change after the handshake does not affect the conversion in progress.

## Timing
- **Reset (asynchronous):** an_out all ones, cat_out 7'h7F, dp_out 1, val_ready_out 1, overflow_out 0. The display register, scan_cnt and digit_idx are cleared, and the FSM goes to IDLE. A reset during SHIFT or COMMIT aborts the conversion with no commit.
- **Output registration:** an_out, cat_out and dp_out are registered, one cycle behind scan_cnt and digit_idx. The first anode goes low on the first edge after reset release.
- **Hex latency:** handshake at edge k updates the display register at edge k. The new digits appear on cat_out from edge k+1. Back-to-back loads are accepted every cycle.
- **Decimal latency:** handshake at edge k puts the FSM in SHIFT for edges k+1..k+W and in COMMIT at edge k+W+1.
  - val_ready_out is low for W+1 cycles and high again after edge k+W+1.
  - The display register and overflow_out update at edge k+W+1.
  - Outputs show the new value from edge k+W+2.
- **Tear-free update:** the display register changes only at a handshake (hex) or at COMMIT. Scanning is never stalled or reset by loads.

## Test plan
Bench parameters: NUM_DIGITS=4, DIGIT_PERIOD=4, BRIGHT_WIDTH=2, brightness 3 unless stated.
- **Reset:** assert rst_n_in low mid-cycle → outputs take their reset values immediately. After release, digit 0 shows 1000000 and digits 1-3 show 0.
- **Hex load:** hex 16'hBEEF → digits 0..3 show F, E, E, B in order. Each anode is low for 4 cycles. val_ready_out stays 1.
- **Decimal load and blanking:**
  - Decimal 16'd1234 → ready low for 17 cycles; digits show 4, 3, 2, 1; overflow_out = 0.
  - Decimal 16'd42 with blank → an_out[3:2] never go low.
- **Overflow:** decimal 16'd10000 → overflow_out = 1 and every digit shows 0111111. A following hex load clears overflow_out.
- **Brightness and dp:** brightness_in = 1 → each anode is low for 2 of 4 cycles. dp_in = 4'b0100 → dp_out = 0 only while an_out[2] is low.
- **Reset mid-conversion and ignored valid:**
  - Pulse reset 5 cycles into a decimal load → no commit; display shows 0; ready = 1.
  - Assert valid while busy → the value is ignored.
